// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared definitions for the register-file port master.
//   DATA_W_DEF : default register data width (32)
//   REG_AW_DEF : default register address width (3 -> 8 registers)
//   state_e    : sequencer states CLEAR (zero-fill), CHECK (readback), RUN
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 3;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_port_master.sv
// regfile_port_master -- initiator of a register-file port.
//
// After reset the block zero-fills every register (CLEAR), optionally reads
// each one back and flags any non-zero value (CHECK), then enters RUN where
// it accepts one read or write request per cycle.
//
// Configuration macro: REGFILE_BIST_EN
//   defined   : CLEAR -> CHECK -> RUN, bist_fail reports readback mismatches
//   undefined : CLEAR -> RUN, bist_fail tied low
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_write/req_ready request handshake (write=1, read=0)
//   req_rs1/req_rs2/req_rd       read addresses, write address
//   req_wdata                    write data
//   rsp_valid, rsp_data1/2       one-cycle read response, latency 2
//   read_reg1/2, read_data1/2    register-file read port (combinational)
//   write_reg/write_data/reg_write register-file write port
//   init_done                    high once in RUN
//   bist_fail                    sticky readback-mismatch flag
module regfile_port_master
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  output logic              req_ready,
  input  logic [REG_AW-1:0] req_rs1,
  input  logic [REG_AW-1:0] req_rs2,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic [REG_AW-1:0] read_reg1,
  output logic [REG_AW-1:0] read_reg2,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic              init_done,
  output logic              bist_fail
);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              init_done_q, init_done_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data1_q, rsp_data1_d;
  logic [DATA_W-1:0] rsp_data2_q, rsp_data2_d;
  logic [REG_AW-1:0] read_reg1_q, read_reg1_d;
  logic [REG_AW-1:0] read_reg2_q, read_reg2_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              reg_write_q, reg_write_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_d      = (state_q == RUN);
    init_done_d  = (state_q == RUN);
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    read_reg1_d  = read_reg1_q;
    read_reg2_d  = read_reg2_q;
    rd_pend_d    = 1'b0;
    // Second pipeline stage: a read whose addresses were driven this cycle
    // captures the register-file data and responds next cycle.
    rsp_valid_d  = rd_pend_q;
    rsp_data1_d  = rsp_data1_q;
    rsp_data2_d  = rsp_data2_q;
    if (rd_pend_q) begin
      rsp_data1_d = read_data1;
      rsp_data2_d = read_data2;
    end

    case (state_q)
      CLEAR: begin
        reg_write_d  = 1'b1;
        write_reg_d  = cnt_q;
        write_data_d = '0;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == '1) begin
`ifdef REGFILE_BIST_EN
          state_d = CHECK;
`else
          state_d = RUN;
`endif
        end
      end
`ifdef REGFILE_BIST_EN
      CHECK: begin
        read_reg1_d = cnt_q;
        read_reg2_d = cnt_q;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = RUN;
        end
      end
`endif
      RUN: begin
        // First pipeline stage: an accepted request drives the register-file
        // port in the following cycle. A write therefore commits one edge
        // before a read accepted right after it samples the file, so no
        // forwarding path is needed.
        if (req_valid && ready_q) begin
          if (req_write) begin
            reg_write_d  = 1'b1;
            write_reg_d  = req_rd;
            write_data_d = req_wdata;
          end else begin
            read_reg1_d = req_rs1;
            read_reg2_d = req_rs2;
            rd_pend_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      init_done_q  <= 1'b0;
      rd_pend_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data1_q  <= '0;
      rsp_data2_q  <= '0;
      read_reg1_q  <= '0;
      read_reg2_q  <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      init_done_q  <= init_done_d;
      rd_pend_q    <= rd_pend_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data1_q  <= rsp_data1_d;
      rsp_data2_q  <= rsp_data2_d;
      read_reg1_q  <= read_reg1_d;
      read_reg2_q  <= read_reg2_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
    end
  end

`ifdef REGFILE_BIST_EN
  // chk_q marks a cycle in which a CHECK address is on the read port, so the
  // compare happens at the edge ending that cycle.
  logic chk_q, chk_d;
  logic bist_fail_q, bist_fail_d;

  always_comb begin
    chk_d       = (state_q == CHECK);
    bist_fail_d = bist_fail_q | (chk_q & (read_data1 != '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q       <= 1'b0;
      bist_fail_q <= 1'b0;
    end else begin
      chk_q       <= chk_d;
      bist_fail_q <= bist_fail_d;
    end
  end

  assign bist_fail = bist_fail_q;
`else
  assign bist_fail = 1'b0;
`endif

  assign req_ready  = ready_q;
  assign init_done  = init_done_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data1  = rsp_data1_q;
  assign rsp_data2  = rsp_data2_q;
  assign read_reg1  = read_reg1_q;
  assign read_reg2  = read_reg2_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign reg_write  = reg_write_q;

endmodule

// File: tb/tb_regfile_port_master.sv
// tb_regfile_port_master -- self-checking bench for regfile_port_master.
// Contains a behavioural 8x32 register file (with an optional corrupt reg 5)
// and scoreboards for read responses and register-file writes.
module tb_regfile_port_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;
`ifdef REGFILE_BIST_EN
  localparam int unsigned INIT_EDGE = 17;
`else
  localparam int unsigned INIT_EDGE = 9;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_write, req_ready;
  logic [AW-1:0] req_rs1, req_rs2, req_rd;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data1, rsp_data2;
  logic [AW-1:0] read_reg1, read_reg2, write_reg;
  logic [DW-1:0] write_data;
  logic          reg_write;
  logic [DW-1:0] read_data1, read_data2;
  logic          init_done, bist_fail;

  always #5 clk = ~clk;

  regfile_port_master #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
    .write_data(write_data), .reg_write(reg_write),
    .read_data1(read_data1), .read_data2(read_data2),
    .init_done(init_done), .bist_fail(bist_fail)
  );

  // Behavioural register file; scramble fills it with non-zero garbage.
  logic [DW-1:0] rf [8];
  logic          scramble = 1'b0;
  logic          stub5 = 1'b0;

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 8; i++) rf[i] <= 32'hBAD0_0000 | 32'(i);
    end else if (reg_write) begin
      rf[write_reg] <= write_data;
    end
  end

  assign read_data1 = (stub5 && read_reg1 == 3'd5) ? 32'hDEAD_BEEF : rf[read_reg1];
  assign read_data2 = (stub5 && read_reg2 == 3'd5) ? 32'hDEAD_BEEF : rf[read_reg2];

  int unsigned cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int unsigned pass_cnt = 0;
  int unsigned tot_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } rexp_t;

  typedef struct {
    int unsigned   due;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wexp_t;

  rexp_t rq[$];
  wexp_t wq[$];
  logic [DW-1:0] shadow [8];

  // Monitor: compares DUT responses and register-file writes to the queues.
  always @(negedge clk) begin
    bit    exp_rv, exp_wv;
    rexp_t r;
    wexp_t w;
    if (!rst) begin
      exp_rv = 1'b0;
      if (rq.size() != 0) exp_rv = (rq[0].due == cyc);
      if (rsp_valid || exp_rv) begin
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (rsp_valid && exp_rv) begin
          r = rq.pop_front();
          chk("rsp_data1", 64'(rsp_data1), 64'(r.d1));
          chk("rsp_data2", 64'(rsp_data2), 64'(r.d2));
        end
      end
      if (init_done) begin
        exp_wv = 1'b0;
        if (wq.size() != 0) exp_wv = (wq[0].due == cyc);
        if (reg_write || exp_wv) begin
          chk("reg_write", 64'(reg_write), 64'(exp_wv));
          if (reg_write && exp_wv) begin
            w = wq.pop_front();
            chk("write_reg", 64'(write_reg), 64'(w.rd));
            chk("write_data", 64'(write_data), 64'(w.data));
          end
        end
      end
    end
  end

  // Drive one request (or an idle cycle when v=0) at the next negedge.
  task automatic issue(input logic v, input logic wr, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                       input logic [DW-1:0] wd, input logic [DW-1:0] e1,
                       input logic [DW-1:0] e2);
    @(negedge clk);
    req_valid = v; req_write = wr; req_rs1 = rs1; req_rs2 = rs2;
    req_rd = rd; req_wdata = wd;
    #1;
    if (v) begin
      chk("req_ready", 64'(req_ready), 64'd1);
      if (req_ready) begin
        if (wr) begin
          wq.push_back('{due: cyc + 1, rd: rd, data: wd});
          shadow[rd] = wd;
        end else begin
          rq.push_back('{due: cyc + 2, d1: e1, d2: e2});
        end
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    idle(4);
    chk("rq_empty", 64'(rq.size()), 64'd0);
    chk("wq_empty", 64'(wq.size()), 64'd0);
  endtask

  // Assert reset now, check zeroed outputs, release, check the clear walk
  // and the init_done edge. hold_req keeps a write request up during CLEAR.
  task automatic reset_and_check(input bit hold_req, input bit exp_bf);
    rst = 1'b1;
    scramble = 1'b1;
    #1;
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_bist_fail", 64'(bist_fail), 64'd0);
    chk("rst_read_reg1", 64'(read_reg1), 64'd0);
    chk("rst_read_reg2", 64'(read_reg2), 64'd0);
    chk("rst_write_reg", 64'(write_reg), 64'd0);
    chk("rst_write_data", 64'(write_data), 64'd0);
    chk("rst_rsp_data1", 64'(rsp_data1), 64'd0);
    rq.delete();
    wq.delete();
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    @(posedge clk);
    @(negedge clk);
    scramble = 1'b0;
    req_valid = hold_req; req_write = 1'b1; req_rd = 3'd6;
    req_rs1 = 3'd4; req_rs2 = 3'd2; req_wdata = 32'hCAFE_F00D;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("clr_reg_write", 64'(reg_write), 64'd1);
      chk("clr_write_reg", 64'(write_reg), 64'(k - 1));
      chk("clr_write_data", 64'(write_data), 64'd0);
      chk("clr_req_ready", 64'(req_ready), 64'd0);
      chk("clr_read_reg1", 64'(read_reg1), 64'd0);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 40 && !init_done; i++) @(negedge clk);
    chk("init_edge", 64'(cyc), 64'(INIT_EDGE));
    chk("init_req_ready", 64'(req_ready), 64'd1);
    chk("init_reg_write", 64'(reg_write), 64'd0);
    chk("init_bist_fail", 64'(bist_fail), 64'(exp_bf));
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] rs1, rs2, rd;
    logic [DW-1:0] wdata;
    logic [DW-1:0] e1, e2;
  } vec_t;

  vec_t tab [8];

  initial begin
    logic [AW-1:0] a1, a2, ad;
    logic          v, wr;
    logic [DW-1:0] wd;

    tab[0] = '{1'b1, 3'd0, 3'd0, 3'd3, 32'h0000_000F, 32'h0, 32'h0};
    tab[1] = '{1'b0, 3'd3, 3'd7, 3'd0, 32'h0, 32'h0000_000F, 32'h0};
    tab[2] = '{1'b1, 3'd0, 3'd0, 3'd7, 32'hA5A5_0000, 32'h0, 32'h0};
    tab[3] = '{1'b0, 3'd7, 3'd3, 3'd0, 32'h0, 32'hA5A5_0000, 32'h0000_000F};
    tab[4] = '{1'b1, 3'd0, 3'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0};
    tab[5] = '{1'b1, 3'd0, 3'd0, 3'd0, 32'h0000_5678, 32'h0, 32'h0};
    tab[6] = '{1'b0, 3'd0, 3'd1, 3'd0, 32'h0, 32'h0000_5678, 32'h0};
    tab[7] = '{1'b0, 3'd1, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0000_5678};

    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_rs1 = '0; req_rs2 = '0;
    req_rd = '0; req_wdata = '0;
    #2;

    // Reset with a request held during CLEAR; reg 6 must still read zero.
    reset_and_check(1'b1, 1'b0);
    issue(1'b1, 1'b0, 3'd6, 3'd6, 3'd0, '0, 32'h0, 32'h0);

    // Table: write then read the next cycle, overwrites, mixed ports.
    for (int i = 0; i < 8; i++)
      issue(1'b1, tab[i].wr, tab[i].rs1, tab[i].rs2, tab[i].rd, tab[i].wdata,
            tab[i].e1, tab[i].e2);
    idle(3);
    chk("hold_read_reg1", 64'(read_reg1), 64'd1);
    chk("hold_read_reg2", 64'(read_reg2), 64'd0);
    drain();

    // 8 back-to-back writes then 8 back-to-back reads.
    for (int i = 0; i < 8; i++)
      issue(1'b1, 1'b1, '0, '0, 3'(i), 32'h100 + 32'(i), '0, '0);
    for (int i = 0; i < 8; i++)
      issue(1'b1, 1'b0, 3'(i), 3'(7 - i), '0, '0, 32'h100 + 32'(i), 32'h107 - 32'(i));
    drain();

    // Random mix of reads, writes and idle cycles.
    for (int i = 0; i < 48; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      wr = 1'($urandom_range(0, 1));
      a1 = 3'($urandom_range(0, 7));
      a2 = 3'($urandom_range(0, 7));
      ad = 3'($urandom_range(0, 7));
      wd = $urandom;
      issue(v, wr, a1, a2, ad, wd, shadow[a1], shadow[a2]);
    end
    drain();

    // Reset while a read is in flight.
    issue(1'b1, 1'b1, '0, '0, 3'd5, 32'h55AA_33CC, '0, '0);
    issue(1'b1, 1'b0, 3'd5, 3'd2, '0, '0, 32'h55AA_33CC, shadow[2]);
    @(negedge clk);
    req_valid = 1'b0;
    chk("inflight_read_reg1", 64'(read_reg1), 64'd5);
    #2;
    reset_and_check(1'b0, 1'b0);
    drain();

`ifdef REGFILE_BIST_EN
    // Corrupt reg 5 in the file: BIST must flag it and still finish init.
    stub5 = 1'b1;
    reset_and_check(1'b0, 1'b1);
    idle(5);
    chk("bist_fail_held", 64'(bist_fail), 64'd1);
    chk("bist_init_done", 64'(init_done), 64'd1);
    stub5 = 1'b0;
`else
    chk("bist_fail_tied", 64'(bist_fail), 64'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
